// File: rtl/btb_port_sched.sv
// Port scheduler for the single-ported BTB array: arbitrates fetch lookups against
// queued branch updates and sequences the full-array invalidation walk.
module btb_port_sched #(
    parameter int DEPTH      = 4,
    parameter int SETS       = 1024,
    parameter int STARVE_MAX = 8,
    localparam int IW = $clog2(SETS),
    localparam int AW = $clog2(DEPTH),
    localparam int SW = $clog2(STARVE_MAX) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          lookup_req,
    output logic          lookup_gnt,
    input  logic          upd_valid,
    input  logic [15:0]   upd_pc,
    input  logic [15:0]   upd_target,
    input  logic          upd_taken,
    output logic          upd_ready,
    input  logic          inv_req,
    output logic          inv_busy,
    output logic          btb_rd,
    output logic          btb_we,
    output logic          btb_clr,
    output logic [IW-1:0] btb_index,
    output logic [15:0]   btb_pc,
    output logic [15:0]   btb_target,
    output logic          btb_taken,
    output logic [AW:0]   qcount
);

    typedef enum logic {ST_INV, ST_SERVE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count_q;
    logic [SW-1:0] starve_q;

    logic [15:0] pc_mem     [DEPTH];
    logic [15:0] target_mem [DEPTH];
    logic        taken_mem  [DEPTH];

    logic empty, full, forced, push, pop;

    assign empty  = (count_q == '0);
    assign full   = (count_q == (AW+1)'(DEPTH));
    assign forced = (starve_q == SW'(STARVE_MAX)) && !empty;
    assign push   = upd_valid && upd_ready;
    assign pop    = btb_we;

    assign btb_rd     = lookup_gnt;
    assign btb_pc     = pc_mem[rd_ptr];
    assign btb_target = target_mem[rd_ptr];
    assign btb_taken  = taken_mem[rd_ptr];
    assign qcount     = count_q;

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        lookup_gnt = 1'b0;
        btb_we     = 1'b0;
        btb_clr    = 1'b0;
        inv_busy   = 1'b0;
        upd_ready  = 1'b0;
        btb_index  = pc_mem[rd_ptr][IW:1];
        case (state_q)
            ST_INV: begin
                btb_clr   = 1'b1;
                inv_busy  = 1'b1;
                btb_index = idx_q;
                if (idx_q == IW'(SETS - 1))
                    state_d = ST_SERVE;
            end
            ST_SERVE: begin
                if (lookup_req && !forced)
                    lookup_gnt = 1'b1;
                else if (!empty)
                    btb_we = 1'b1;
                // No write-through: a full FIFO refuses even when popping this cycle.
                upd_ready = !full && !inv_req;
                if (inv_req)
                    state_d = ST_INV;
            end
            default: state_d = ST_INV;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= ST_INV;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            starve_q <= '0;
        end else if (state_q == ST_INV) begin
            idx_q <= (idx_q == IW'(SETS - 1)) ? '0 : idx_q + IW'(1);
        end else if (inv_req) begin
            // The arbitration of this cycle still drives the array; the queue is discarded.
            idx_q    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            starve_q <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
            if (empty || pop)
                starve_q <= '0;
            else if (lookup_gnt && starve_q != SW'(STARVE_MAX))
                starve_q <= starve_q + SW'(1);
        end
    end

    // NOTE: FIFO storage has no reset; occupancy and pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]     <= upd_pc;
            target_mem[wr_ptr] <= upd_target;
            taken_mem[wr_ptr]  <= upd_taken;
        end
    end

endmodule

// File: tb/tb_btb_port_sched.sv
// Self-checking bench for btb_port_sched: directed sequences, a vector table and
// randomized traffic compared against a queue-based reference model.
module tb_btb_port_sched;

    localparam int DEPTH = 4;
    localparam int SETS  = 8;
    localparam int SMAX  = 8;
    localparam int IW    = $clog2(SETS);
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          reset;
    logic          lookup_req, upd_valid, upd_taken, inv_req;
    logic [15:0]   upd_pc, upd_target;
    logic          lookup_gnt, upd_ready, inv_busy, btb_rd, btb_we, btb_clr, btb_taken;
    logic [IW-1:0] btb_index;
    logic [15:0]   btb_pc, btb_target;
    logic [AW:0]   qcount;

    btb_port_sched #(.DEPTH(DEPTH), .SETS(SETS), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .lookup_req(lookup_req), .lookup_gnt(lookup_gnt),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
        .upd_taken(upd_taken), .upd_ready(upd_ready),
        .inv_req(inv_req), .inv_busy(inv_busy),
        .btb_rd(btb_rd), .btb_we(btb_we), .btb_clr(btb_clr), .btb_index(btb_index),
        .btb_pc(btb_pc), .btb_target(btb_target), .btb_taken(btb_taken),
        .qcount(qcount)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending updates as a queue, invalidation as a flag plus walk index.
    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] tgt;
        logic        tk;
    } upd_t;

    upd_t mq[$];
    int   m_starve;
    bit   m_inv;
    int   m_idx;
    bit   e_gnt, e_we, e_ready;

    task automatic model_reset();
        mq.delete();
        m_starve = 0;
        m_inv    = 1'b1;
        m_idx    = 0;
    endtask

    // Drive one cycle's inputs (at the falling edge) and compare every output to the model.
    task automatic drive(input bit lr, input bit uv, input logic [15:0] pc,
                         input logic [15:0] tgt, input bit tk, input bit inv);
        bit forced;
        lookup_req = lr;
        upd_valid  = uv;
        upd_pc     = pc;
        upd_target = tgt;
        upd_taken  = tk;
        inv_req    = inv;
        #1;
        if (m_inv) begin
            e_gnt = 0; e_we = 0; e_ready = 0;
        end else begin
            forced  = (m_starve == SMAX) && (mq.size() != 0);
            e_gnt   = lr && !forced;
            e_we    = !e_gnt && (mq.size() != 0);
            e_ready = (mq.size() < DEPTH) && !inv;
        end
        check("lookup_gnt", 32'(lookup_gnt), 32'(e_gnt));
        check("btb_rd", 32'(btb_rd), 32'(e_gnt));
        check("btb_we", 32'(btb_we), 32'(e_we));
        check("btb_clr", 32'(btb_clr), 32'(m_inv));
        check("inv_busy", 32'(inv_busy), 32'(m_inv));
        check("upd_ready", 32'(upd_ready), 32'(e_ready));
        check("qcount", 32'(qcount), 32'(mq.size()));
        if (m_inv)
            check("clr_index", 32'(btb_index), 32'(m_idx));
        if (e_we) begin
            check("we_index", 32'(btb_index), 32'((mq[0].pc >> 1) % SETS));
            check("btb_pc", 32'(btb_pc), 32'(mq[0].pc));
            check("btb_target", 32'(btb_target), 32'(mq[0].tgt));
            check("btb_taken", 32'(btb_taken), 32'(mq[0].tk));
        end
    endtask

    // Advance past the rising edge, apply the same edge to the model, stop at the falling edge.
    task automatic tick();
        int sz;
        upd_t e;
        @(posedge clk);
        if (m_inv) begin
            if (m_idx == SETS - 1) m_inv = 1'b0;
            m_idx = (m_idx + 1) % SETS;
        end else begin
            sz = mq.size();
            if (e_we) void'(mq.pop_front());
            if (upd_valid && e_ready) begin
                e.pc = upd_pc; e.tgt = upd_target; e.tk = upd_taken;
                mq.push_back(e);
            end
            if (sz == 0 || e_we) m_starve = 0;
            else if (e_gnt && m_starve < SMAX) m_starve++;
            if (inv_req) begin
                m_inv = 1'b1; m_idx = 0; m_starve = 0; mq.delete();
            end
        end
        @(negedge clk);
    endtask

    typedef struct {
        bit          lr, uv, inv;
        logic [15:0] pc;
        int          gnt, we, rdy, q;
    } vec_t;

    vec_t vt[11];

    initial begin
        // Fill four entries under continuous lookups, then see the forced pop of a full FIFO.
        vt[0]  = '{1, 1, 0, 16'h1002, 1, 0, 1, 0};
        vt[1]  = '{1, 1, 0, 16'h1004, 1, 0, 1, 1};
        vt[2]  = '{1, 1, 0, 16'h1006, 1, 0, 1, 2};
        vt[3]  = '{1, 1, 0, 16'h1008, 1, 0, 1, 3};
        vt[4]  = '{1, 1, 0, 16'h100a, 1, 0, 0, 4};
        vt[5]  = '{1, 0, 0, 16'h0000, 1, 0, 0, 4};
        vt[6]  = '{1, 0, 0, 16'h0000, 1, 0, 0, 4};
        vt[7]  = '{1, 0, 0, 16'h0000, 1, 0, 0, 4};
        vt[8]  = '{1, 0, 0, 16'h0000, 1, 0, 0, 4};
        vt[9]  = '{1, 1, 0, 16'h100a, 0, 1, 0, 4};
        vt[10] = '{1, 0, 0, 16'h0000, 1, 0, 1, 3};

        reset = 1'b1;
        lookup_req = 1'b1; upd_valid = 1'b0; upd_pc = '0; upd_target = '0;
        upd_taken = 1'b0; inv_req = 1'b0;
        model_reset();
        #3;
        check("rst_busy", 32'(inv_busy), 32'd1);
        check("rst_clr", 32'(btb_clr), 32'd1);
        check("rst_index", 32'(btb_index), 32'd0);
        check("rst_gnt", 32'(lookup_gnt), 32'd0);
        check("rst_ready", 32'(upd_ready), 32'd0);

        // Post-reset walk covers every set once, then the port is served.
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < SETS; i++) begin
            drive(0, 0, '0, '0, 0, 0);
            check("walk_index", 32'(btb_index), 32'(i));
            check("walk_busy", 32'(inv_busy), 32'd1);
            tick();
        end

        // Idle port: an accepted update is written on the following cycle.
        drive(0, 1, 16'h3002, 16'h3040, 1, 0);
        check("serve_busy", 32'(inv_busy), 32'd0);
        check("serve_ready", 32'(upd_ready), 32'd1);
        check("serve_q", 32'(qcount), 32'd0);
        tick();
        drive(0, 0, '0, '0, 0, 0);
        check("idle_we", 32'(btb_we), 32'd1);
        check("idle_index", 32'(btb_index), 32'd1);
        check("idle_target", 32'(btb_target), 32'h3040);
        tick();
        drive(0, 0, '0, '0, 0, 0);
        check("idle_drained", 32'(qcount), 32'd0);
        tick();

        for (int v = 0; v < 11; v++) begin
            drive(vt[v].lr, vt[v].uv, vt[v].pc, vt[v].pc + 16'h0100, vt[v].pc[1], vt[v].inv);
            check($sformatf("vec%0d_gnt", v), 32'(lookup_gnt), 32'(vt[v].gnt));
            check($sformatf("vec%0d_we", v), 32'(btb_we), 32'(vt[v].we));
            check($sformatf("vec%0d_ready", v), 32'(upd_ready), 32'(vt[v].rdy));
            check($sformatf("vec%0d_q", v), 32'(qcount), 32'(vt[v].q));
            tick();
        end

        // Invalidate with three queued entries and a concurrent update.
        drive(1, 1, 16'h2222, 16'h4444, 0, 1);
        check("inv_cycle_ready", 32'(upd_ready), 32'd0);
        check("inv_cycle_gnt", 32'(lookup_gnt), 32'd1);
        tick();
        for (int i = 0; i < SETS; i++) begin
            drive(1, 0, '0, '0, 0, (i == 3));
            if (i == 0) begin
                check("inv_flush_q", 32'(qcount), 32'd0);
                check("inv_gnt", 32'(lookup_gnt), 32'd0);
            end
            check("inv_walk_busy", 32'(inv_busy), 32'd1);
            check("inv_walk_index", 32'(btb_index), 32'(i));
            tick();
        end
        drive(1, 0, '0, '0, 0, 0);
        check("inv_done_busy", 32'(inv_busy), 32'd0);
        check("inv_done_gnt", 32'(lookup_gnt), 32'd1);
        tick();

        // Reset asserted mid-walk at index 5.
        drive(0, 1, 16'h5556, 16'h6666, 0, 1);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, '0, '0, 0, 0);
            tick();
        end
        drive(1, 0, '0, '0, 0, 0);
        check("pre_rst_index", 32'(btb_index), 32'd5);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_busy", 32'(inv_busy), 32'd1);
        check("mid_rst_clr", 32'(btb_clr), 32'd1);
        check("mid_rst_index", 32'(btb_index), 32'd0);
        check("mid_rst_gnt", 32'(lookup_gnt), 32'd0);
        check("mid_rst_we", 32'(btb_we), 32'd0);
        check("mid_rst_ready", 32'(upd_ready), 32'd0);
        check("mid_rst_q", 32'(qcount), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < SETS; i++) begin
            drive(1, 0, '0, '0, 0, 0);
            check("rewalk_index", 32'(btb_index), 32'(i));
            tick();
        end

        // Randomized traffic against the reference model.
        for (int n = 0; n < 1500; n++) begin
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, 16'($urandom),
                  16'($urandom), 1'($urandom), $urandom_range(0, 199) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/btb_port_sched.md
# btb_port_sched

Scheduler for the single-ported branch target buffer. It shares the BTB array between fetch-stage lookups and resolved-branch updates from the execute stage, and it sequences full-array invalidation. Pending updates sit in a small FIFO. Lookups normally win the port, but a starvation counter forces an update through when the FIFO has waited too long. The block sits between the fetch stage, the branch-resolution logic and the BTB array.

## Interface
Parameters:
- DEPTH, 4: update FIFO entries (power of two, ≥2)
- SETS, 1024: BTB sets; index width IW = log2(SETS)
- STARVE_MAX, 8: consecutive lost arbitrations before an update is forced

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- lookup_req  in  1  fetch requests a BTB read this cycle
- lookup_gnt  out  1  read granted this cycle (combinational)
- upd_valid  in  1  resolved branch presents an update
- upd_pc  in  16  branch PC (lc3b_word)
- upd_target  in  16  branch target (lc3b_word)
- upd_taken  in  1  resolved direction
- upd_ready  out  1  FIFO accepts; transfer when upd_valid & upd_ready at edge
- inv_req  in  1  invalidate entire BTB
- inv_busy  out  1  invalidation walk in progress
- btb_rd  out  1  array read strobe (= lookup_gnt)
- btb_we  out  1  array write of FIFO head this cycle
- btb_clr  out  1  clear all valid bits of set btb_index
- btb_index  out  IW  set for the current write or clear; during writes = head upd_pc[IW:1]
- btb_pc / btb_target  out  16 each  FIFO head pc / target
- btb_taken  out  1  FIFO head taken
- qcount  out  log2(DEPTH)+1  FIFO occupancy

## Operation
- States: INV (walk), SERVE. Exactly one of btb_rd, btb_we, btb_clr is high in any cycle, or none is.
- SERVE arbitration, evaluated combinationally each cycle:
  - forced = (starve == STARVE_MAX) & (qcount != 0).
  - If lookup_req & !forced: grant the lookup (lookup_gnt = btb_rd = 1).
  - Otherwise, if qcount != 0: btb_we = 1 and pop the head at the edge.
  - Otherwise: idle.
- Starve counter, width log2(STARVE_MAX)+1:
  - Increments when qcount != 0 and a lookup wins.
  - Clears when an update issues or the FIFO is empty.
  - Saturates at STARVE_MAX.
- FIFO:
  - upd_ready = !full & (state == SERVE) & !inv_req.
  - There is no write-through: when full, upd_ready = 0 even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full: qcount is unchanged and order is preserved.
  - A pushed entry becomes the head no earlier than the next cycle.
  - Pointers wrap modulo DEPTH.
- inv_req in SERVE:
  - The current cycle's arbitration still completes.
  - At the edge: state ← INV, idx ← 0, FIFO flushed (qcount ← 0), starve ← 0.
  - Any concurrent upd_valid is not accepted, because upd_ready = 0.
- INV:
  - btb_clr = 1, btb_index = idx, inv_busy = 1.
  - lookup_gnt = 0, upd_ready = 0, btb_we = 0.
  - idx increments each cycle.
  - After the cycle with idx == SETS-1, state ← SERVE.
  - inv_req is ignored in INV; it does not restart the walk.
- Reset (asynchronous, mid-operation included): state ← INV, idx ← 0, FIFO empty, starve ← 0. A post-reset walk runs so that the valid bits are defined.
- Output values while reset is held: inv_busy = 1, btb_clr = 1, btb_index = 0, lookup_gnt = btb_rd = btb_we = 0, upd_ready = 0, qcount = 0.
- btb_pc, btb_target and btb_taken are don't-care when btb_we = 0.

## Timing
- Arbitration outputs (lookup_gnt, btb_rd, btb_we, btb_index, btb_* data) are combinational from registered state and the current lookup_req. There is no input-to-output path from upd_* or inv_req except the inv_req term in upd_ready.
- Update latency: an entry accepted at edge N can be written to the array no earlier than cycle N+1.
- Worst-case update latency under continuous lookups: (position in FIFO) × (STARVE_MAX+1) cycles.
- Invalidation occupies exactly SETS cycles. The first SERVE cycle follows the cycle in which idx == SETS-1.
- With reset released at edge 0, SERVE begins at cycle SETS.

## Test plan
- Reset release, SETS=8: btb_clr high for 8 cycles with btb_index 0..7 and inv_busy = 1. Cycle 8: inv_busy = 0, upd_ready = 1, qcount = 0.
- Idle port:
  - Stimulus: push pc=0x3002, target=0x3040, taken=1 with lookup_req = 0.
  - Next cycle: btb_we = 1, btb_index = 1, btb_target = 0x3040.
  - Following cycle: qcount = 0.
- Starvation:
  - Stimulus: lookup_req held at 1, one entry queued, STARVE_MAX = 8.
  - Lookups are granted for 8 cycles. The 9th cycle gives lookup_gnt = 0 and btb_we = 1.
  - Lookups are granted again afterwards with starve = 0.
- Full FIFO, DEPTH = 4:
  - Stimulus: push 4 entries under continuous lookups.
  - upd_ready = 0 with qcount = 4, including the cycle of a forced pop. After that pop, upd_ready = 1.
- Invalidate mid-traffic:
  - Stimulus: qcount = 3, then inv_req pulsed one cycle together with upd_valid.
  - Next cycle: qcount = 0, inv_busy = 1, lookup_gnt = 0. The concurrent update is dropped.
  - A second inv_req pulse during the walk does not extend it beyond SETS cycles.
- Reset asserted mid-walk at idx = 5: outputs return to reset values immediately, and the walk restarts from index 0 after release.
